// File: rtl/bsg_mcl_axil_pkg.sv
// Shared definitions for the AXI-Lite rx read controller: response codes,
// register offsets within a channel window, and the read FSM states.
package bsg_mcl_axil_pkg;

  localparam logic [1:0] resp_okay_lp   = 2'b00;
  localparam logic [1:0] resp_slverr_lp = 2'b10;
  localparam logic [1:0] resp_decerr_lp = 2'b11;

  localparam int data_ofs_lp  = 'h0;
  localparam int count_ofs_lp = 'h4;

  typedef enum logic [1:0] {e_idle, e_lookup, e_resp} rd_state_e;

  // A single channel still needs a 1-bit index to keep port widths legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mcl_axil_rx_rd_ctrl_if.sv
// AXI-Lite read-channel bundle (AR + R) between host and rx read controller.
interface bsg_mcl_axil_rx_rd_ctrl_if #(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
);
  logic [addr_width_p-1:0] araddr;
  logic                    arvalid;
  logic                    arready;
  logic [data_width_p-1:0] rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (output araddr, arvalid, rready, input arready, rdata, rresp, rvalid);
  modport slave  (input araddr, arvalid, rready, output arready, rdata, rresp, rvalid);
endinterface

// File: rtl/bsg_mcl_axil_rx_decode.sv
// Combinational decode of a captured read address into channel index and
// DATA/COUNT register select, flagging anything outside the channel windows.
module bsg_mcl_axil_rx_decode
  import bsg_mcl_axil_pkg::*;
#(
  parameter int          num_chan_p        = 2,
  parameter int          axil_addr_width_p = 32,
  parameter int unsigned base_addr_p       = 0,
  parameter int          chan_stride_p     = 16,
  parameter int          idx_width_p       = idx_width(num_chan_p)
) (
  input  logic [axil_addr_width_p-1:0] addr_i,
  output logic                         hit_o,
  output logic                         is_count_o,
  output logic [idx_width_p-1:0]       chan_o
);
  localparam int          stride_lg_lp = $clog2(chan_stride_p);
  localparam logic [63:0] win_lp       = 64'(num_chan_p) * 64'(chan_stride_p);

  logic [63:0]             off;
  logic [stride_lg_lp-1:0] reg_ofs;
  logic                    in_range, is_data;

  // 64-bit math keeps the window test exact even when the top window touches 2^addr_width.
  assign off      = 64'(addr_i) - 64'(base_addr_p);
  assign in_range = (64'(addr_i) >= 64'(base_addr_p)) && (off < win_lp);
  assign reg_ofs  = {off[stride_lg_lp-1:2], 2'b00};

  assign is_data    = reg_ofs == stride_lg_lp'(data_ofs_lp);
  assign is_count_o = reg_ofs == stride_lg_lp'(count_ofs_lp);
  assign hit_o      = in_range && (is_data || is_count_o);
  assign chan_o     = off[stride_lg_lp +: idx_width_p];

endmodule

// File: rtl/bsg_mcl_axil_rx_rd_ctrl.sv
// Shares one AXI-Lite read port among num_chan_p rx channels: DATA pops the
// channel head word, COUNT samples its credit count. One read in flight.
module bsg_mcl_axil_rx_rd_ctrl
  import bsg_mcl_axil_pkg::*;
#(
  parameter int          num_chan_p        = 2,
  parameter int          axil_data_width_p = 32,
  parameter int          axil_addr_width_p = 32,
  parameter int          count_width_p     = 8,
  parameter int unsigned base_addr_p       = 0,
  parameter int          chan_stride_p     = 16
) (
  input  logic                                    clk_i,
  input  logic                                    reset_n_i,
  bsg_mcl_axil_rx_rd_ctrl_if.slave                axil,
  input  logic [num_chan_p*axil_data_width_p-1:0] chan_data_i,
  input  logic [num_chan_p-1:0]                   chan_v_i,
  output logic [num_chan_p-1:0]                   chan_yumi_o,
  input  logic [num_chan_p*count_width_p-1:0]     chan_count_i
);
  localparam int idx_w_lp = idx_width(num_chan_p);

  rd_state_e                                       state_r, state_n;
  logic [axil_addr_width_p-1:0]                    addr_r;
  logic [axil_data_width_p-1:0]                    rdata_r, rdata_n;
  logic [1:0]                                      rresp_r, rresp_n;
  logic                                            hit, is_count, ar_fire;
  logic [idx_w_lp-1:0]                             chan;
  logic [num_chan_p-1:0][axil_data_width_p-1:0]    chan_data;
  logic [num_chan_p-1:0][count_width_p-1:0]        chan_count;

  assign chan_data  = chan_data_i;
  assign chan_count = chan_count_i;

  bsg_mcl_axil_rx_decode #(
    .num_chan_p        (num_chan_p),
    .axil_addr_width_p (axil_addr_width_p),
    .base_addr_p       (base_addr_p),
    .chan_stride_p     (chan_stride_p),
    .idx_width_p       (idx_w_lp)
  ) decode (
    .addr_i     (addr_r),
    .hit_o      (hit),
    .is_count_o (is_count),
    .chan_o     (chan)
  );

  // arready is gated by reset so the host never sees a handshake while held in reset.
  assign axil.arready = (state_r == e_idle) && reset_n_i;
  assign axil.rvalid  = (state_r == e_resp);
  assign axil.rdata   = rdata_r;
  assign axil.rresp   = rresp_r;
  assign ar_fire      = axil.arvalid && axil.arready;

  always_comb begin
    state_n     = state_r;
    rdata_n     = '0;
    rresp_n     = resp_decerr_lp;
    chan_yumi_o = '0;
    case (state_r)
      e_idle:   if (ar_fire) state_n = e_lookup;
      e_lookup: begin
        state_n = e_resp;
        if (hit) begin
          if (is_count) begin
            rdata_n = axil_data_width_p'(chan_count[chan]);
            rresp_n = resp_okay_lp;
          end else if (chan_v_i[chan]) begin
            rdata_n           = chan_data[chan];
            rresp_n           = resp_okay_lp;
            chan_yumi_o[chan] = 1'b1;
          end else begin
            rresp_n = resp_slverr_lp;
          end
        end
      end
      e_resp:   if (axil.rready) state_n = e_idle;
      default:  state_n = e_idle;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= e_idle;
      addr_r  <= '0;
      rdata_r <= '0;
      rresp_r <= resp_okay_lp;
    end else begin
      state_r <= state_n;
      if (ar_fire) addr_r <= axil.araddr;
      if (state_r == e_lookup) begin
        rdata_r <= rdata_n;
        rresp_r <= rresp_n;
      end
    end
  end

endmodule

// File: tb/tb_bsg_mcl_axil_rx_rd_ctrl.sv
// Randomized bench: queue-based rx channel model plus address-arithmetic
// predictor, scoreboarded every cycle, with literal anchors for directed reads.
module tb_bsg_mcl_axil_rx_rd_ctrl;
  import bsg_mcl_axil_pkg::*;

  localparam int          NCH    = 2;
  localparam int          DW     = 32;
  localparam int          AW     = 32;
  localparam int          CW     = 8;
  localparam int          STRIDE = 16;
  localparam int unsigned BASE   = 0;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic [1:0]    rresp;
  } rsp_t;

  logic              clk_i = 1'b0;
  logic              reset_n_i = 1'b0;
  logic [NCH*DW-1:0] chan_data_i;
  logic [NCH-1:0]    chan_v_i;
  logic [NCH-1:0]    chan_yumi_o;
  logic [NCH*CW-1:0] chan_count_i;

  bsg_mcl_axil_rx_rd_ctrl_if #(.addr_width_p(AW), .data_width_p(DW)) axil ();

  bsg_mcl_axil_rx_rd_ctrl #(
    .num_chan_p(NCH), .axil_data_width_p(DW), .axil_addr_width_p(AW),
    .count_width_p(CW), .base_addr_p(BASE), .chan_stride_p(STRIDE)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .axil         (axil),
    .chan_data_i  (chan_data_i),
    .chan_v_i     (chan_v_i),
    .chan_yumi_o  (chan_yumi_o),
    .chan_count_i (chan_count_i)
  );

  always #5 clk_i = ~clk_i;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [DW-1:0] fifo [NCH][$];
  logic [CW-1:0] cnt [NCH];
  rsp_t          exp_q[$];
  int            exp_pop_q[$];
  int            rsp_head = 0;
  int            pop_head = 0;
  logic [NCH-1:0] pend_pop = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", name, act, exp);
  endtask

  task automatic drive_chans();
    for (int c = 0; c < NCH; c++) begin
      chan_v_i[c]             = fifo[c].size() != 0;
      chan_data_i[c*DW +: DW] = (fifo[c].size() != 0) ? fifo[c][0] : DW'($urandom);
      chan_count_i[c*CW +: CW] = cnt[c];
    end
  endtask

  // Drive point: just after the rising edge; apply any pop seen in the last cycle.
  task automatic tick();
    @(posedge clk_i);
    #1;
    for (int c = 0; c < NCH; c++)
      if (pend_pop[c] && fifo[c].size() != 0) void'(fifo[c].pop_front());
    drive_chans();
  endtask

  task automatic predict(input logic [AW-1:0] a, output rsp_t r, output int pc);
    longint off;
    int     c, rsel;
    pc      = -1;
    r.rdata = '0;
    r.rresp = 2'b11;
    off = longint'({32'b0, a}) - longint'(BASE);
    if (off < 0 || off >= NCH * STRIDE) return;
    c    = int'(off / STRIDE);
    rsel = int'((off % STRIDE) / 4);
    if (rsel == 1) begin
      r.rdata = DW'(cnt[c]);
      r.rresp = 2'b00;
    end else if (rsel == 0) begin
      if (fifo[c].size() != 0) begin
        r.rdata = fifo[c][0];
        r.rresp = 2'b00;
        pc      = c;
      end else begin
        r.rresp = 2'b10;
      end
    end
  endtask

  // Cycle-by-cycle scoreboard: pops against expected pops, R beats against predictions.
  initial forever begin
    @(negedge clk_i);
    pend_pop = '0;
    if (!reset_n_i) begin
      check("rst_arready", axil.arready, 0);
      check("rst_rvalid", axil.rvalid, 0);
      check("rst_rdata", axil.rdata, 0);
      check("rst_rresp", axil.rresp, 0);
      check("rst_yumi", chan_yumi_o, 0);
    end else begin
      if (chan_yumi_o != '0) begin
        check("yumi_onehot", $onehot(chan_yumi_o), 1);
        check("yumi_needs_v", chan_yumi_o & ~chan_v_i, 0);
        if (pop_head >= exp_pop_q.size()) check("yumi_unexpected", chan_yumi_o, 0);
        else begin
          check("yumi_chan", chan_yumi_o, NCH'(1) << exp_pop_q[pop_head]);
          pop_head++;
        end
        pend_pop = chan_yumi_o;
      end
      if (axil.rvalid && axil.rready) begin
        if (rsp_head >= exp_q.size()) check("rsp_unexpected", axil.rvalid, 0);
        else begin
          check("rdata", axil.rdata, exp_q[rsp_head].rdata);
          check("rresp", axil.rresp, exp_q[rsp_head].rresp);
          rsp_head++;
        end
      end
    end
  end

  task automatic issue_ar(input logic [AW-1:0] a);
    int n;
    tick();
    axil.araddr  = a;
    axil.arvalid = 1'b1;
    axil.rready  = 1'b0;
    @(negedge clk_i);
    n = 0;
    while (!axil.arready && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    check("ar_accept", axil.arready, 1);
    tick();
    axil.arvalid = 1'b0;
    axil.araddr  = $urandom;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int hold,
                         output logic [DW-1:0] rd, output logic [1:0] rr);
    rsp_t e;
    int   pc;
    predict(a, e, pc);
    exp_q.push_back(e);
    if (pc >= 0) exp_pop_q.push_back(pc);
    issue_ar(a);
    @(negedge clk_i);
    check("lookup_rvalid", axil.rvalid, 0);
    check("lookup_arready", axil.arready, 0);
    tick();
    @(negedge clk_i);
    check("rvalid_n2", axil.rvalid, 1);
    rd = axil.rdata;
    rr = axil.rresp;
    for (int i = 0; i < hold; i++) begin
      tick();
      axil.arvalid = 1'b1;
      axil.araddr  = AW'(BASE);
      @(negedge clk_i);
      check("hold_rvalid", axil.rvalid, 1);
      check("hold_rdata", axil.rdata, e.rdata);
      check("hold_rresp", axil.rresp, e.rresp);
      check("hold_arready", axil.arready, 0);
    end
    tick();
    axil.rready  = 1'b1;
    axil.arvalid = 1'b0;
    @(negedge clk_i);
    tick();
    axil.rready = 1'b0;
    @(negedge clk_i);
    check("next_ar_ready", axil.arready, 1);
    check("pops_done", pop_head, exp_pop_q.size());
    check("rsps_done", rsp_head, exp_q.size());
  endtask

  // Reset during LOOKUP (when==0) or RESP (when==1); the response is never expected.
  task automatic reset_in(input int when, input logic [AW-1:0] a, input int pc);
    if (when == 1) exp_pop_q.push_back(pc);
    issue_ar(a);
    if (when == 1) begin
      @(negedge clk_i);
      tick();
    end
    reset_n_i = 1'b0;
    @(negedge clk_i);
    tick();
    @(negedge clk_i);
    tick();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("post_rst_arready", axil.arready, 1);
  endtask

  initial begin
    logic [DW-1:0] rd;
    logic [1:0]    rr;
    logic [AW-1:0] a;
    logic [AW-1:0] bad [5];
    int            c;

    axil.araddr  = '0;
    axil.arvalid = 1'b0;
    axil.rready  = 1'b0;
    for (int i = 0; i < NCH; i++) cnt[i] = '0;
    drive_chans();
    repeat (3) @(negedge clk_i);
    tick();
    reset_n_i = 1'b1;
    @(negedge clk_i);
    check("idle_arready", axil.arready, 1);

    fifo[1].push_back(32'hA5A5_0001);
    drive_chans();
    do_read(32'h10, 0, rd, rr);
    check("t1_rdata", rd, 32'hA5A5_0001);
    check("t1_rresp", rr, 2'b00);
    check("t1_popped", fifo[1].size(), 0);

    do_read(32'h0, 0, rd, rr);
    check("t2_rdata", rd, 0);
    check("t2_rresp", rr, 2'b10);

    cnt[0] = 8'd5;
    drive_chans();
    repeat (2) begin
      do_read(32'h4, 0, rd, rr);
      check("t3_rdata", rd, 32'h5);
      check("t3_rresp", rr, 2'b00);
    end

    fifo[0].push_back(32'hDDDD_0000);
    drive_chans();
    bad = '{32'h20, 32'h8, 32'hC, 32'h18, 32'hFFFF_FFF0};
    foreach (bad[i]) begin
      do_read(bad[i], 0, rd, rr);
      check("t4_rdata", rd, 0);
      check("t4_rresp", rr, 2'b11);
    end
    check("t4_no_pop", fifo[0].size(), 1);

    do_read(32'h3, 0, rd, rr);
    check("lowbits_rdata", rd, 32'hDDDD_0000);
    cnt[1] = 8'hFF;
    drive_chans();
    do_read(32'h17, 0, rd, rr);
    check("cnt1_rdata", rd, 32'hFF);

    fifo[0].push_back(32'h5000_0001);
    drive_chans();
    do_read(32'h0, 10, rd, rr);
    check("t5_hold_rdata", rd, 32'h5000_0001);
    check("t5_single_pop", fifo[0].size(), 0);
    for (int i = 1; i <= 3; i++) fifo[0].push_back(32'h6000_0000 + i);
    drive_chans();
    for (int i = 1; i <= 3; i++) begin
      do_read(32'h0, 0, rd, rr);
      check("t5_order", rd, 32'h6000_0000 + i);
    end

    fifo[0].push_back(32'hC0DE_0000);
    drive_chans();
    reset_in(0, 32'h0, 0);
    do_read(32'h0, 0, rd, rr);
    check("t6_lookup_rst", rd, 32'hC0DE_0000);
    fifo[1].push_back(32'hBEEF_0001);
    fifo[1].push_back(32'hBEEF_0002);
    drive_chans();
    reset_in(1, 32'h10, 1);
    do_read(32'h10, 0, rd, rr);
    check("t6_resp_rst", rd, 32'hBEEF_0002);

    repeat (60) begin
      if ($urandom_range(0, 1) == 1) fifo[$urandom_range(0, NCH-1)].push_back($urandom);
      cnt[$urandom_range(0, NCH-1)] = CW'($urandom);
      drive_chans();
      c = $urandom_range(0, NCH-1);
      case ($urandom_range(0, 3))
        0:       a = AW'(BASE + c*STRIDE + $urandom_range(0, 1)*4 + $urandom_range(0, 3));
        1:       a = AW'(BASE + NCH*STRIDE + $urandom_range(0, 255));
        2:       a = AW'(BASE + c*STRIDE + 8 + $urandom_range(0, 7));
        default: a = $urandom;
      endcase
      do_read(a, $urandom_range(0, 3), rd, rr);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
